// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: instruction fetch that talks to the IM over an in-order req/gnt/rvalid handshake
// and keeps prefetched words in a FIFO for ID. Optional FETCH_BYPASS_EN forwards a response straight to ID.
module fetch_prefetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_im_req,
    output logic [ADDR_W-1:0] o_im_addr,
    input  logic              i_im_gnt,
    input  logic              i_im_rvalid,
    input  logic [DATA_W-1:0] i_im_rdata,
    output logic              o_id_valid,
    output logic [DATA_W-1:0] o_id_instr,
    output logic [ADDR_W-1:0] o_id_pc,
    input  logic              i_id_ready,
    input  logic              i_redirect_en,
    input  logic [ADDR_W-1:0] i_redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_resp_pc;
    logic [ADDR_W-1:0] r_pc_q    [DEPTH];
    logic [DATA_W-1:0] r_instr_q [DEPTH];
    logic [PW-1:0]     r_rd;
    logic [PW-1:0]     r_wr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     r_outst;
    logic [CW-1:0]     r_drop;

    logic              w_credit;
    logic              w_fire;
    logic              w_resp;
    logic              w_take;
    logic              w_push;
    logic              w_head_valid;
    logic              w_pop;
    logic [CW:0]       w_inflight;
    logic [ADDR_W-1:0] w_head_pc;
    logic [DATA_W-1:0] w_head_instr;

    // Buffered plus in-flight words never exceed DEPTH, so a response always has a free slot.
    assign w_inflight   = {1'b0, r_count} + {1'b0, r_outst};
    assign w_credit     = w_inflight < (CW+1)'(DEPTH);
    assign o_im_req     = !i_rst && !i_redirect_en && w_credit;
    assign o_im_addr    = r_fetch_pc;
    assign w_fire       = o_im_req && i_im_gnt;

    assign w_resp       = i_im_rvalid && (r_outst != '0);
    assign w_take       = w_resp && (r_drop == '0) && !i_redirect_en;
    assign w_head_valid = (r_count != '0) && !i_redirect_en;
    assign w_pop        = w_head_valid && i_id_ready;
    assign w_head_pc    = r_pc_q[r_rd];
    assign w_head_instr = r_instr_q[r_rd];

`ifdef FETCH_BYPASS_EN
    logic w_bypass;

    assign w_bypass   = w_take && (r_count == '0);
    assign w_push     = w_take && !(w_bypass && i_id_ready);
    assign o_id_valid = w_head_valid || w_bypass;
    assign o_id_instr = w_head_valid ? w_head_instr : (w_bypass ? i_im_rdata : '0);
    assign o_id_pc    = w_head_valid ? w_head_pc    : (w_bypass ? r_resp_pc  : '0);
`else
    assign w_push     = w_take;
    assign o_id_valid = w_head_valid;
    assign o_id_instr = w_head_valid ? w_head_instr : '0;
    assign o_id_pc    = w_head_valid ? w_head_pc    : '0;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_pc_q[r_wr]    <= r_resp_pc;
            r_instr_q[r_wr] <= i_im_rdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            r_outst    <= '0;
            r_drop     <= '0;
        end else if (i_redirect_en) begin
            r_fetch_pc <= i_redirect_pc;
            r_resp_pc  <= i_redirect_pc;
            r_rd       <= '0;
            r_wr       <= '0;
            r_count    <= '0;
            // Everything still in flight is stale; pending drops are already counted in r_outst.
            r_outst    <= r_outst - CW'(w_resp);
            r_drop     <= r_outst - CW'(w_resp);
        end else begin
            if (w_fire) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end
            if (w_take) begin
                r_resp_pc <= r_resp_pc + ADDR_W'(4);
            end
            if (w_resp && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            r_outst <= r_outst + CW'(w_fire) - CW'(w_resp);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with a behavioural in-order IM (1-cycle latency, hold control).
module tb_fetch_prefetch_unit;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic              im_gnt = 1'b0;
    logic              im_rvalid;
    logic [DATA_W-1:0] im_rdata;
    logic              id_valid;
    logic [DATA_W-1:0] id_instr;
    logic [ADDR_W-1:0] id_pc;
    logic              id_ready = 1'b0;
    logic              redir = 1'b0;
    logic [ADDR_W-1:0] redir_pc = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic              im_hold = 1'b0;
    logic              rst_s;
    logic [ADDR_W-1:0] pend[$];
    logic [ADDR_W-1:0] got_pc[$];
    logic [DATA_W-1:0] got_ins[$];
    int                got_cyc[$];
    logic [ADDR_W-1:0] exp_pc;
    logic [ADDR_W-1:0] e;
    int                t0;

    fetch_prefetch_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .i_clk(clk), .i_rst(rst),
        .o_im_req(im_req), .o_im_addr(im_addr), .i_im_gnt(im_gnt),
        .i_im_rvalid(im_rvalid), .i_im_rdata(im_rdata),
        .o_id_valid(id_valid), .o_id_instr(id_instr), .o_id_pc(id_pc),
        .i_id_ready(id_ready),
        .i_redirect_en(redir), .i_redirect_pc(redir_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem(input logic [15:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    // IM model: grant seen in cycle t -> response offered from cycle t+1, strictly in order.
    initial begin
        im_rvalid = 1'b0;
        im_rdata  = '0;
        forever begin
            @(negedge clk);
            rst_s = rst;
            if (!rst && im_req && im_gnt) pend.push_back(im_addr);
            @(posedge clk);
            #2;
            if (rst_s) pend.delete();
            else if (im_rvalid) pend.delete(0);
            if (!rst_s && !im_hold && pend.size() > 0) begin
                im_rvalid = 1'b1;
                im_rdata  = mem(pend[0]);
            end else begin
                im_rvalid = 1'b0;
                im_rdata  = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            got_pc.push_back(id_pc);
            got_ins.push_back(id_instr);
            got_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_got();
        got_pc.delete();
        got_ins.delete();
        got_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; im_gnt = 1'b0; id_ready = 1'b0; redir = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL reset_im_req: got %b expected 0", im_req); end
            n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
        end
        n_cmp++; if (id_instr !== 32'h0) begin n_err++; $display("FAIL reset_id_instr: got %h expected 0", id_instr); end
        n_cmp++; if (id_pc !== 16'h0) begin n_err++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
        step();
        rst = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b1) begin n_err++; $display("FAIL post_reset_im_req: got %b expected 1", im_req); end
        n_cmp++; if (im_addr !== 16'h0000) begin n_err++; $display("FAIL post_reset_im_addr: got %h expected 0000", im_addr); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_id_valid: got %b expected 0", id_valid); end
        exp_pc = 16'h0000;
    endtask

    task automatic test_stream();
        clear_got();
        step();
        im_gnt = 1'b1; t0 = cyc;
        repeat (12) step();
        im_gnt = 1'b0;
        repeat (6) step();
        @(negedge clk);
        n_cmp++; if (got_pc.size() !== 12) begin n_err++; $display("FAIL stream_count: got %0d expected 12", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            e = exp_pc + 16'(4 * i);
            n_cmp++; if (got_pc[i] !== e) begin n_err++; $display("FAIL stream_pc[%0d]: got %h expected %h", i, got_pc[i], e); end
            n_cmp++; if (got_ins[i] !== mem(e)) begin n_err++; $display("FAIL stream_instr[%0d]: got %h expected %h", i, got_ins[i], mem(e)); end
            n_cmp++; if (got_cyc[i] !== t0 + LAT + i) begin n_err++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, got_cyc[i], t0 + LAT + i); end
        end
        exp_pc = exp_pc + 16'(4 * got_pc.size());
        n_cmp++; if (im_addr !== exp_pc) begin n_err++; $display("FAIL stream_next_addr: got %h expected %h", im_addr, exp_pc); end
    endtask

    task automatic test_stall();
        clear_got();
        step();
        im_gnt = 1'b1; id_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL stall_im_req: got %b expected 0", im_req); end
        n_cmp++; if (id_valid !== 1'b1) begin n_err++; $display("FAIL stall_id_valid: got %b expected 1", id_valid); end
        n_cmp++; if (id_pc !== exp_pc) begin n_err++; $display("FAIL stall_id_pc: got %h expected %h", id_pc, exp_pc); end
        n_cmp++; if (id_instr !== mem(exp_pc)) begin n_err++; $display("FAIL stall_id_instr: got %h expected %h", id_instr, mem(exp_pc)); end
        step();
        id_ready = 1'b1;
        repeat (8) step();
        im_gnt = 1'b0;
        repeat (6) step();
        @(negedge clk);
        n_cmp++; if (got_pc.size() < 8) begin n_err++; $display("FAIL stall_count: got %0d expected at least 8", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            e = exp_pc + 16'(4 * i);
            n_cmp++; if (got_pc[i] !== e) begin n_err++; $display("FAIL stall_pc[%0d]: got %h expected %h", i, got_pc[i], e); end
            n_cmp++; if (got_ins[i] !== mem(e)) begin n_err++; $display("FAIL stall_instr[%0d]: got %h expected %h", i, got_ins[i], mem(e)); end
        end
        exp_pc = exp_pc + 16'(4 * got_pc.size());
        n_cmp++; if (im_addr !== exp_pc) begin n_err++; $display("FAIL stall_next_addr: got %h expected %h", im_addr, exp_pc); end
    endtask

    // One word buffered, one response arriving in the redirect cycle, one more still in flight.
    task automatic test_redirect();
        clear_got();
        step();
        im_gnt = 1'b1; id_ready = 1'b0; im_hold = 1'b0;
        step();
        step();
        im_hold = 1'b1;
        step();
        redir = 1'b1; redir_pc = 16'h0100; im_hold = 1'b0;
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b0) begin n_err++; $display("FAIL redir_cycle_im_req: got %b expected 0", im_req); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_cycle_id_valid: got %b expected 0", id_valid); end
        step();
        redir = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (im_req !== 1'b1) begin n_err++; $display("FAIL redir_next_im_req: got %b expected 1", im_req); end
        n_cmp++; if (im_addr !== 16'h0100) begin n_err++; $display("FAIL redir_next_im_addr: got %h expected 0100", im_addr); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL redir_next_id_valid: got %b expected 0", id_valid); end
        repeat (5) step();
        im_gnt = 1'b0;
        repeat (6) step();
        @(negedge clk);
        n_cmp++; if (got_pc.size() !== 5) begin n_err++; $display("FAIL redir_count: got %0d expected 5", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            e = 16'h0100 + 16'(4 * i);
            n_cmp++; if (got_pc[i] !== e) begin n_err++; $display("FAIL redir_pc[%0d]: got %h expected %h", i, got_pc[i], e); end
            n_cmp++; if (got_ins[i] !== mem(e)) begin n_err++; $display("FAIL redir_instr[%0d]: got %h expected %h", i, got_ins[i], mem(e)); end
        end
        exp_pc = 16'h0114;
        n_cmp++; if (im_addr !== exp_pc) begin n_err++; $display("FAIL redir_next_addr: got %h expected %h", im_addr, exp_pc); end
    endtask

    task automatic test_back_to_back();
        clear_got();
        step();
        im_gnt = 1'b1; im_hold = 1'b1;
        step();
        step();
        redir = 1'b1; redir_pc = 16'h0200; im_hold = 1'b0;
        step();
        redir_pc = 16'h0300;
        step();
        redir = 1'b0;
        @(negedge clk);
        n_cmp++; if (im_addr !== 16'h0300) begin n_err++; $display("FAIL b2b_im_addr: got %h expected 0300", im_addr); end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL b2b_id_valid: got %b expected 0", id_valid); end
        repeat (5) step();
        im_gnt = 1'b0;
        repeat (6) step();
        @(negedge clk);
        n_cmp++; if (got_pc.size() !== 5) begin n_err++; $display("FAIL b2b_count: got %0d expected 5", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            e = 16'h0300 + 16'(4 * i);
            n_cmp++; if (got_pc[i] !== e) begin n_err++; $display("FAIL b2b_pc[%0d]: got %h expected %h", i, got_pc[i], e); end
            n_cmp++; if (got_ins[i] !== mem(e)) begin n_err++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, got_ins[i], mem(e)); end
        end
        exp_pc = 16'h0314;
        n_cmp++; if (im_addr !== exp_pc) begin n_err++; $display("FAIL b2b_next_addr: got %h expected %h", im_addr, exp_pc); end
    endtask

    task automatic test_wrap();
        clear_got();
        step();
        redir = 1'b1; redir_pc = 16'hFFFC; im_gnt = 1'b1;
        step();
        redir = 1'b0;
        @(negedge clk);
        n_cmp++; if (im_addr !== 16'hFFFC) begin n_err++; $display("FAIL wrap_im_addr: got %h expected fffc", im_addr); end
        repeat (4) step();
        im_gnt = 1'b0;
        repeat (6) step();
        @(negedge clk);
        n_cmp++; if (got_pc.size() !== 4) begin n_err++; $display("FAIL wrap_count: got %0d expected 4", got_pc.size()); end
        for (int i = 0; i < got_pc.size(); i++) begin
            e = 16'hFFFC + 16'(4 * i);
            n_cmp++; if (got_pc[i] !== e) begin n_err++; $display("FAIL wrap_pc[%0d]: got %h expected %h", i, got_pc[i], e); end
            n_cmp++; if (got_ins[i] !== mem(e)) begin n_err++; $display("FAIL wrap_instr[%0d]: got %h expected %h", i, got_ins[i], mem(e)); end
        end
        exp_pc = 16'h000C;
        n_cmp++; if (im_addr !== exp_pc) begin n_err++; $display("FAIL wrap_next_addr: got %h expected %h", im_addr, exp_pc); end
    endtask

    task automatic test_latency();
        clear_got();
        step();
        im_gnt = 1'b1; t0 = cyc;
        step();
        im_gnt = 1'b0;
        repeat (5) step();
        @(negedge clk);
        n_cmp++; if (got_pc.size() !== 1) begin n_err++; $display("FAIL lat_count: got %0d expected 1", got_pc.size()); end
        if (got_pc.size() > 0) begin
            n_cmp++; if (got_cyc[0] !== t0 + LAT) begin n_err++; $display("FAIL lat_cycle: got %0d expected %0d", got_cyc[0], t0 + LAT); end
            n_cmp++; if (got_pc[0] !== exp_pc) begin n_err++; $display("FAIL lat_pc: got %h expected %h", got_pc[0], exp_pc); end
            n_cmp++; if (got_ins[0] !== mem(exp_pc)) begin n_err++; $display("FAIL lat_instr: got %h expected %h", got_ins[0], mem(exp_pc)); end
        end
        n_cmp++; if (id_valid !== 1'b0) begin n_err++; $display("FAIL lat_idle_valid: got %b expected 0", id_valid); end
        exp_pc = exp_pc + 16'h0004;
        n_cmp++; if (im_addr !== exp_pc) begin n_err++; $display("FAIL lat_next_addr: got %h expected %h", im_addr, exp_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
